// File: rtl/persiana_pkg.sv
// Shared definitions for the blind motor driver.
// Provides the state encoding (visible on state_dbg), datapath widths and
// the default values of the driver's parameters.
package persiana_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_UP   = 3'd1,
    ST_RUN_DOWN = 3'd2,
    ST_DEAD     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam int DUTY_W    = 8;
  localparam int RUN_CNT_W = 16;

  localparam int DEF_TICK_DIV      = 1000;
  localparam int DEF_DEAD_TICKS    = 8;
  localparam int DEF_RAMP_INC      = 16;
  localparam int DEF_TIMEOUT_TICKS = 4000;

endpackage

// File: rtl/persiana_motor_driver_if.sv
// Bundle between the blind control FSM (master) and the motor driver (slave).
//   subir/bajar       : raise/lower request levels
//   limit_sup/inf     : end-stop sensors (1 = at limit)
//   clear_fault       : level, leaves FAULT
//   motor_up/down     : PWM drive outputs
//   moving/fault      : status flags
//   state_dbg         : encoded driver state
interface persiana_motor_driver_if;
  logic       subir;
  logic       bajar;
  logic       limit_sup;
  logic       limit_inf;
  logic       clear_fault;
  logic       motor_up;
  logic       motor_down;
  logic       moving;
  logic       fault;
  logic [2:0] state_dbg;

  modport master (
    output subir, bajar, limit_sup, limit_inf, clear_fault,
    input  motor_up, motor_down, moving, fault, state_dbg
  );

  modport slave (
    input  subir, bajar, limit_sup, limit_inf, clear_fault,
    output motor_up, motor_down, moving, fault, state_dbg
  );
endinterface

// File: rtl/persiana_tick_gen.sv
// Free-running timing tick generator.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset
//   tick_o  : one-cycle strobe every TICK_DIV clocks
// The counter never restarts on driver state changes, only on reset.
module persiana_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/persiana_motor_driver.sv
// Blind motor driver: soft-start PWM drive in two directions with end-stop
// handling, dead time between runs and a run timeout that latches a fault.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of persiana_motor_driver_if (requests, sensors,
//           clear_fault in; drives, moving, fault, state_dbg out)
module persiana_motor_driver
  import persiana_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int DEAD_TICKS    = DEF_DEAD_TICKS,
  parameter int RAMP_INC      = DEF_RAMP_INC,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input logic                    clk,
  input logic                    reset,
  persiana_motor_driver_if.slave bus
);

  localparam logic [DUTY_W:0]      RAMP_L    = (DUTY_W+1)'(RAMP_INC);
  localparam logic [RUN_CNT_W-1:0] TIMEOUT_L = RUN_CNT_W'(TIMEOUT_TICKS);
  localparam logic [RUN_CNT_W-1:0] DEAD_LAST = RUN_CNT_W'(DEAD_TICKS - 1);

  // Saturating soft-start step: 9-bit sum clamped to 255.
  function automatic logic [DUTY_W-1:0] duty_ramp(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + RAMP_L;
    return sum[DUTY_W] ? {DUTY_W{1'b1}} : sum[DUTY_W-1:0];
  endfunction

  state_t                 state_q;
  logic [DUTY_W-1:0]      duty_q;
  logic [DUTY_W-1:0]      duty_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q;
  logic [RUN_CNT_W-1:0]   run_cnt_d;
  logic [RUN_CNT_W-1:0]   dead_cnt_q;
  logic [DUTY_W-1:0]      pwm_q;
  logic                   motor_up_q;
  logic                   motor_down_q;
  logic                   tick;
  logic                   req_up;
  logic                   req_down;
  logic                   stop_up;
  logic                   stop_down;
  logic                   timeout;

  persiana_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick)
  );

  // Both requests together count as no request.
  assign req_up    = bus.subir & ~bus.bajar;
  assign req_down  = bus.bajar & ~bus.subir;
  assign stop_up   = ~req_up   | bus.limit_sup;
  assign stop_down = ~req_down | bus.limit_inf;
  assign duty_d    = duty_ramp(duty_q);
  assign run_cnt_d = run_cnt_q + 1'b1;
  assign timeout   = tick && (run_cnt_d == TIMEOUT_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      run_cnt_q    <= '0;
      dead_cnt_q   <= '0;
      pwm_q        <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
    end else begin
      pwm_q        <= pwm_q + 1'b1;
      // Drives derive from a single state, so they can never overlap.
      motor_up_q   <= (state_q == ST_RUN_UP)   && (pwm_q < duty_q);
      motor_down_q <= (state_q == ST_RUN_DOWN) && (pwm_q < duty_q);

      case (state_q)
        ST_IDLE: begin
          if (req_up && !bus.limit_sup) begin
            state_q   <= ST_RUN_UP;
            duty_q    <= '0;
            run_cnt_q <= '0;
          end else if (req_down && !bus.limit_inf) begin
            state_q   <= ST_RUN_DOWN;
            duty_q    <= '0;
            run_cnt_q <= '0;
          end
        end

        ST_RUN_UP, ST_RUN_DOWN: begin
          // Timeout wins over a stop condition arriving in the same cycle.
          if (timeout) begin
            state_q <= ST_FAULT;
          end else if ((state_q == ST_RUN_UP) ? stop_up : stop_down) begin
            state_q    <= ST_DEAD;
            dead_cnt_q <= '0;
          end else if (tick) begin
            duty_q    <= duty_d;
            run_cnt_q <= run_cnt_d;
          end
        end

        ST_DEAD: begin
          if (tick) begin
            if (dead_cnt_q == DEAD_LAST) state_q <= ST_IDLE;
            else                         dead_cnt_q <= dead_cnt_q + 1'b1;
          end
        end

        ST_FAULT: begin
          if (bus.clear_fault) begin
            state_q    <= ST_DEAD;
            dead_cnt_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, not just after the edge.
  assign bus.motor_up   = motor_up_q   & ~reset;
  assign bus.motor_down = motor_down_q & ~reset;
  assign bus.moving     = ~reset & ((state_q == ST_RUN_UP) || (state_q == ST_RUN_DOWN));
  assign bus.fault      = ~reset & (state_q == ST_FAULT);
  assign bus.state_dbg  = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_persiana_motor_driver.sv
module tb_persiana_motor_driver;

  localparam int TICK_DIV      = 4;
  localparam int DEAD_TICKS    = 2;
  localparam int RAMP_INC      = 64;
  localparam int TIMEOUT_TICKS = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  persiana_motor_driver_if bus_if ();

  persiana_motor_driver #(
    .TICK_DIV      (TICK_DIV),
    .DEAD_TICKS    (DEAD_TICKS),
    .RAMP_INC      (RAMP_INC),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0..4 as named by the state list, time counted in
  // clk edges since reset; duty is derived from ticks spent in the run.
  int m_state     = 0;
  int m_run_ticks = 0;
  int m_dead      = 0;
  int m_cyc       = 0;
  int m_mu        = 0;
  int m_md        = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input int ticks);
    int d;
    d = ticks * RAMP_INC;
    return (d > 255) ? 255 : d;
  endfunction

  task automatic model_edge();
    bit tick;
    int pwm;
    int duty;
    bit rq_up, rq_dn;
    if (reset) begin
      m_state = 0; m_run_ticks = 0; m_dead = 0; m_cyc = 0; m_mu = 0; m_md = 0;
      return;
    end
    tick  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    pwm   = m_cyc % 256;
    duty  = duty_of(m_run_ticks);
    m_mu  = (m_state == 1 && pwm < duty) ? 1 : 0;
    m_md  = (m_state == 2 && pwm < duty) ? 1 : 0;
    rq_up = bus_if.subir && !bus_if.bajar;
    rq_dn = bus_if.bajar && !bus_if.subir;
    case (m_state)
      0: begin
        if (rq_up && !bus_if.limit_sup) begin m_state = 1; m_run_ticks = 0; end
        else if (rq_dn && !bus_if.limit_inf) begin m_state = 2; m_run_ticks = 0; end
      end
      1, 2: begin
        bit stop;
        stop = (m_state == 1) ? (!rq_up || bus_if.limit_sup) : (!rq_dn || bus_if.limit_inf);
        if (tick && (m_run_ticks + 1 == TIMEOUT_TICKS)) m_state = 4;
        else if (stop) begin m_state = 3; m_dead = 0; end
        else if (tick) m_run_ticks++;
      end
      3: begin
        if (tick) begin
          m_dead++;
          if (m_dead == DEAD_TICKS) m_state = 0;
        end
      end
      default: begin
        if (bus_if.clear_fault) begin m_state = 3; m_dead = 0; end
      end
    endcase
    m_cyc++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("motor_up",   {7'd0, bus_if.motor_up},   reset ? 8'd0 : 8'(m_mu));
    chk("motor_down", {7'd0, bus_if.motor_down}, reset ? 8'd0 : 8'(m_md));
    chk("moving",     {7'd0, bus_if.moving},     (!reset && (m_state == 1 || m_state == 2)) ? 8'd1 : 8'd0);
    chk("fault",      {7'd0, bus_if.fault},      (!reset && m_state == 4) ? 8'd1 : 8'd0);
    chk("state_dbg",  {5'd0, bus_if.state_dbg},  reset ? 8'd0 : 8'(m_state));
    chk("drive_excl", {7'd0, bus_if.motor_up & bus_if.motor_down}, 8'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input bit s, input bit b, input bit ls, input bit li, input bit cf);
    bus_if.subir = s; bus_if.bajar = b; bus_if.limit_sup = ls;
    bus_if.limit_inf = li; bus_if.clear_fault = cf;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    // Reset held: outputs low throughout.
    run(3);
    reset = 1'b0;
    run(2);
    chk("reset_idle", {5'd0, bus_if.state_dbg}, 8'd0);

    // Soft start upward.
    set_in(1, 0, 0, 0, 0);
    cyc();
    chk("run_up_entry", {5'd0, bus_if.state_dbg}, 8'd1);
    run(20);

    // End-stop reached mid-run.
    set_in(1, 0, 1, 0, 0);
    cyc();
    chk("endstop_dead", {5'd0, bus_if.state_dbg}, 8'd3);
    cyc();
    chk("endstop_drive_off", {7'd0, bus_if.motor_up}, 8'd0);
    run(14);
    chk("endstop_idle", {5'd0, bus_if.state_dbg}, 8'd0);

    // Reversal from full duty.
    set_in(1, 0, 0, 0, 0);
    run(18);
    set_in(0, 1, 0, 0, 0);
    cyc();
    chk("rev_dead", {5'd0, bus_if.state_dbg}, 8'd3);
    run(30);

    // Reset while running down.
    reset = 1'b1;
    cyc();
    chk("rst_run_down_state", {5'd0, bus_if.state_dbg}, 8'd0);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    cyc();
    chk("rst_after_drive", {7'd0, bus_if.motor_down}, 8'd0);

    // Timeout and fault recovery.
    set_in(1, 0, 0, 0, 0);
    run(95);
    chk("timeout_fault", {7'd0, bus_if.fault}, 8'd1);
    set_in(1, 0, 0, 0, 1);
    cyc();
    set_in(0, 0, 0, 0, 0);
    run(20);
    chk("fault_cleared", {5'd0, bus_if.state_dbg}, 8'd0);

    // Conflicting requests.
    set_in(1, 1, 0, 0, 0);
    run(12);
    chk("conflict_idle", {5'd0, bus_if.state_dbg}, 8'd0);

    // Randomized phase: inputs re-rolled occasionally so runs develop.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        set_in(r < 5, (r >= 4 && r < 9), $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      end
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/persiana_motor_driver.md
PERSIANA_MOTOR_DRIVER -- requirements
Module: persiana_motor_driver

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per internal timing tick (>=2).
REQ-002 Parameter DEAD_TICKS, default 8: ticks of forced motor-off between any stop and the next start.
REQ-003 Parameter RAMP_INC, default 16: duty increment per tick during soft start (1..255).
REQ-004 Parameter TIMEOUT_TICKS, default 4000: maximum ticks in one run before fault (<=65535).
REQ-005 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: reset is synchronous and active-high.
REQ-007 Port subir, input, 1: raise request from the blind FSM, level.
REQ-008 Port bajar, input, 1: lower request from the blind FSM, level.
REQ-009 Port limit_sup, input, 1: upper end-stop sensor, 1 = blind fully up.
REQ-010 Port limit_inf, input, 1: lower end-stop sensor, 1 = blind fully down.
REQ-011 Port clear_fault, input, 1: level, leaves FAULT.
REQ-012 Port motor_up, output, 1: PWM drive, raise direction.
REQ-013 Port motor_down, output, 1: PWM drive, lower direction.
REQ-014 Port moving, output, 1: 1 while in RUN_UP or RUN_DOWN.
REQ-015 Port fault, output, 1: 1 while in FAULT.
REQ-016 Port state_dbg, output, 3: encoded current state.

Function
REQ-017 States: IDLE=0, RUN_UP=1, RUN_DOWN=2, DEAD=3, FAULT=4; state_dbg equals the current encoding.
REQ-018 Tick: one-clk strobe every TICK_DIV cycles from a free-running counter; the counter does not restart on state changes.
REQ-019 IDLE: subir=1, bajar=0, limit_sup=0 -> RUN_UP next clk; bajar=1, subir=0, limit_inf=0 -> RUN_DOWN next clk; otherwise stay.
REQ-020 subir=bajar=1 is treated as no request in every state.
REQ-021 RUN_UP -> DEAD when subir=0, bajar=1, or limit_sup=1; RUN_DOWN mirrors with bajar/limit_inf.
REQ-022 Entering a RUN state clears duty and run counter to 0.
REQ-023 Each tick in a RUN state: duty <= min(255, duty+RAMP_INC), 9-bit intermediate sum, saturating, no wrap.
REQ-024 Each tick in a RUN state increments the 16-bit run counter; on reaching TIMEOUT_TICKS -> FAULT at that tick; timeout takes priority over stop conditions in the same cycle.
REQ-025 DEAD: counts DEAD_TICKS ticks, then IDLE; requests ignored while counting.
REQ-026 FAULT: stays until clear_fault=1, then DEAD; requests ignored.
REQ-027 PWM: 8-bit counter increments every clk, wraps 255->0; drive active when pwm_cnt < duty, so duty 0 = always off and 255 = on 255/256 of cycles.
REQ-028 motor_up = registered (state==RUN_UP && pwm_cnt<duty); motor_down likewise; one clk latency from state/duty.
REQ-029 motor_up and motor_down are never 1 in the same cycle, including across direction reversal and reset.
REQ-030 All outputs are 0 in IDLE, DEAD and FAULT except fault and state_dbg.
REQ-031 Reversal (subir->bajar while running) is always RUN_UP -> DEAD -> IDLE -> RUN_DOWN.

Reset
REQ-032 On reset=1 at a clk edge: state=IDLE, duty=0, run counter=0, dead counter=0, tick counter=0, pwm_cnt=0.
REQ-033 During and the cycle after reset: motor_up=0, motor_down=0, moving=0, fault=0, state_dbg=0.
REQ-034 Reset mid-run or in FAULT acts immediately; no DEAD interval is enforced after reset.

Structure
REQ-035 Shared package persiana_pkg: state encoding, DUTY_W=8, RUN_CNT_W=16, default parameter constants.
REQ-036 One sub-module, persiana_tick_gen, parameterized by TICK_DIV, outputs the tick strobe.

Verification (TICK_DIV=4, DEAD_TICKS=2, RAMP_INC=64, TIMEOUT_TICKS=20)
REQ-037 Soft start: subir=1 from IDLE -> RUN_UP next clk; duty 64,128,192,255 on successive ticks, then holds 255; motor_down stays 0.
REQ-038 End-stop: limit_sup=1 mid-run -> DEAD next clk, motor_up=0 one clk later, IDLE after 2 ticks; subir held with limit_sup=1 stays IDLE.
REQ-039 Reversal: RUN_UP with duty 255, switch to bajar -> DEAD, IDLE, RUN_DOWN with duty restarting at 0; no cycle with both drives high.
REQ-040 Timeout: hold subir with limits 0 -> FAULT on 20th run tick, fault=1, drives 0; clear_fault=1 -> DEAD -> IDLE.
REQ-041 Conflict and reset: subir=bajar=1 in IDLE stays IDLE; reset asserted in RUN_DOWN -> all outputs 0 and state_dbg=0 next cycle.
